// File: rtl/slave_read_interface_pkg.sv
// Shared types and constants for the per-slave DDR read port.
// Widths and defaults are common with the write-side interface.
package slave_read_interface_pkg;
   localparam int BANK_W  = 2;
   localparam int PARAM_W = 1;
   localparam int SLAVE_W = 4;
   localparam int OFFS_W  = 18;
   localparam int ADDR_W  = BANK_W + PARAM_W + SLAVE_W + OFFS_W;
   localparam int LEN_W   = 10;
   localparam int FILL_W  = 11;

   localparam logic [LEN_W-1:0]  DEF_BURST_LEN  = 10'd256;
   localparam logic [OFFS_W-1:0] DEF_MAXADDR    = 18'd245_760;
   localparam logic [FILL_W-1:0] DEF_FIFO_DEPTH = 11'd1024;

   typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, BUSY, DONE} rd_state_t;

   typedef struct packed {
      logic [BANK_W-1:0]  bank;
      logic [PARAM_W-1:0] param;
      logic [SLAVE_W-1:0] slave;
      logic [OFFS_W-1:0]  offset;
   } rd_addr_t;
endpackage

// File: rtl/slave_read_interface_if.sv
// Consumer / arbiter / bank-manager signals of one DDR read slave.
interface slave_read_interface_if;
   import slave_read_interface_pkg::*;

   logic              frame_start;
   logic [LEN_W-1:0]  fifo_len;
   logic              fifo_full_flag;
   logic              slave_req;
   logic              arbitrate_valid;
   logic              slave_rd_load;
   logic [BANK_W-1:0] slave_rdbank;
   logic [ADDR_W-1:0] slave_raddr;
   logic [LEN_W-1:0]  slave_rburst_len;
   logic              slave_frame_finished;
   logic              frame_abort_error;

   modport slave (
      input  frame_start, fifo_len, fifo_full_flag, arbitrate_valid, slave_rd_load, slave_rdbank,
      output slave_req, slave_raddr, slave_rburst_len, slave_frame_finished, frame_abort_error
   );

   modport master (
      output frame_start, fifo_len, fifo_full_flag, arbitrate_valid, slave_rd_load, slave_rdbank,
      input  slave_req, slave_raddr, slave_rburst_len, slave_frame_finished, frame_abort_error
   );
endinterface

// File: rtl/slave_burst_addr_gen.sv
// Burst offset counter, frame-complete compare and DDR address assembly.
// The frame bank is captured only on bank_load so it stays fixed for a frame.
module slave_burst_addr_gen
   import slave_read_interface_pkg::*;
#(
   parameter logic [SLAVE_W-1:0] SLAVE_NUMBER = 4'b0000,
   parameter logic               PARAM_BIT    = 1'b0,
   parameter logic [OFFS_W-1:0]  MAXADDR      = DEF_MAXADDR,
   parameter logic [LEN_W-1:0]   BURST_LEN    = DEF_BURST_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_load,
   input  logic [BANK_W-1:0] rdbank,
   input  logic              bank_load,
   input  logic              clr,
   input  logic              inc,
   output logic              last,
   output logic              offset_nz,
   output logic [OFFS_W-1:0] raddr_reg,
   output logic [ADDR_W-1:0] addr
);
   localparam logic [OFFS_W-1:0] STEP = OFFS_W'(BURST_LEN);

   logic [BANK_W-1:0] r_rdbank;
   logic [BANK_W-1:0] frame_bank;
   rd_addr_t          fields;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdbank   <= '0;
         frame_bank <= '0;
         raddr_reg  <= '0;
      end else begin
         if (rd_load)
            r_rdbank <= rdbank;
         if (bank_load)
            frame_bank <= r_rdbank;
         if (clr)
            raddr_reg <= '0;
         else if (inc)
            raddr_reg <= raddr_reg + STEP;
      end
   end

   assign last      = (raddr_reg + STEP) == MAXADDR;
   assign offset_nz = |raddr_reg;

   assign fields = '{bank: frame_bank, param: PARAM_BIT, slave: SLAVE_NUMBER, offset: raddr_reg};
   assign addr   = fields;
endmodule

// File: rtl/slave_read_interface.sv
// Per-slave DDR read port: requests 256-word bursts whenever the TX read FIFO
// has room, walks the frame offset and reports completion / framing errors.
module slave_read_interface
   import slave_read_interface_pkg::*;
#(
   parameter logic [SLAVE_W-1:0] SLAVE_NUMBER = 4'b0000,
   parameter logic               PARAM_BIT    = 1'b0,
   parameter logic [OFFS_W-1:0]  MAXADDR      = DEF_MAXADDR,
   parameter logic [LEN_W-1:0]   BURST_LEN    = DEF_BURST_LEN,
   parameter logic [FILL_W-1:0]  FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input logic                   ddr_clk,
   input logic                   sys_rst,
   slave_read_interface_if.slave bus
);
   localparam logic [OFFS_W-1:0] STEP = OFFS_W'(BURST_LEN);

   rd_state_t         state;
   logic              pending;
   logic              valid_d;
   logic              burst_done;
   logic              restart;
   logic              space_ok;
   logic [FILL_W-1:0] room;
   logic              last;
   logic              offset_nz;
   logic              clr;
   logic              inc;
   logic              bank_load;
   logic [OFFS_W-1:0] raddr_reg;

   assign burst_done = valid_d & ~bus.arbitrate_valid;
   assign restart    = burst_done & (pending | bus.frame_start);
   assign room       = FIFO_DEPTH - {1'b0, bus.fifo_len};
   assign space_ok   = ~bus.fifo_full_flag & (room >= {1'b0, BURST_LEN});

   // A running burst is never cut short; a new frame takes effect at its end.
   always_comb begin
      clr       = 1'b0;
      inc       = 1'b0;
      bank_load = 1'b0;
      case (state)
         BUSY: begin
            if (burst_done) begin
               bank_load = restart;
               clr       = restart | last;
               inc       = ~restart & ~last;
            end
         end
         default: begin
            clr       = bus.frame_start;
            bank_load = bus.frame_start;
         end
      endcase
   end

   slave_burst_addr_gen #(
      .SLAVE_NUMBER (SLAVE_NUMBER),
      .PARAM_BIT    (PARAM_BIT),
      .MAXADDR      (MAXADDR),
      .BURST_LEN    (BURST_LEN)
   ) u_addr_gen (
      .clk       (ddr_clk),
      .rst       (sys_rst),
      .rd_load   (bus.slave_rd_load),
      .rdbank    (bus.slave_rdbank),
      .bank_load (bank_load),
      .clr       (clr),
      .inc       (inc),
      .last      (last),
      .offset_nz (offset_nz),
      .raddr_reg (raddr_reg),
      .addr      (bus.slave_raddr)
   );

   always_ff @(posedge ddr_clk) begin
      if (sys_rst) begin
         state                    <= IDLE;
         pending                  <= 1'b0;
         valid_d                  <= 1'b0;
         bus.slave_req            <= 1'b0;
         bus.slave_rburst_len     <= '0;
         bus.slave_frame_finished <= 1'b0;
         bus.frame_abort_error    <= 1'b0;
      end else begin
         bus.slave_rburst_len  <= BURST_LEN;
         valid_d               <= bus.arbitrate_valid;
         bus.frame_abort_error <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.frame_start) begin
                  bus.slave_frame_finished <= 1'b0;
                  state                    <= WAIT_SPACE;
               end
            end
            WAIT_SPACE: begin
               if (bus.frame_start)
                  bus.frame_abort_error <= offset_nz;
               if (space_ok) begin
                  bus.slave_req <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (bus.frame_start)
                  bus.frame_abort_error <= offset_nz;
               if (bus.arbitrate_valid) begin
                  bus.slave_req <= 1'b0;
                  state         <= BUSY;
               end
            end
            BUSY: begin
               if (bus.frame_start)
                  bus.frame_abort_error <= 1'b1;
               if (burst_done) begin
                  pending <= 1'b0;
                  if (!restart && last) begin
                     bus.slave_frame_finished <= 1'b1;
                     state                    <= DONE;
                  end else begin
                     state <= WAIT_SPACE;
                  end
               end else if (bus.frame_start) begin
                  pending <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_offs_bound: assert property (@(posedge ddr_clk) disable iff (sys_rst)
      (state == BUSY) |-> (raddr_reg <= MAXADDR - STEP));
endmodule

// File: tb/tb_slave_read_interface.sv
// Randomised self-checking bench for slave_read_interface with a 4-burst frame.
module tb_slave_read_interface;
   import slave_read_interface_pkg::*;

   localparam logic [17:0] MAXA   = 18'd1024;
   localparam int          NBURST = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   slave_read_interface_if bus();

   slave_read_interface #(
      .SLAVE_NUMBER (4'b0000),
      .PARAM_BIT    (1'b0),
      .MAXADDR      (MAXA),
      .BURST_LEN    (10'd256),
      .FIFO_DEPTH   (11'd1024)
   ) dut (
      .ddr_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Address model: bank selects an 8M-word region, each burst advances 256 words.
   function automatic logic [24:0] exp_addr(input int bank, input int idx);
      return 25'(bank * 32'h0080_0000 + idx * 256);
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_bank(input int b);
      bus.slave_rdbank  = 2'(b);
      bus.slave_rd_load = 1'b1;
      tick();
      bus.slave_rd_load = 1'b0;
   endtask

   task automatic start_frame();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic wait_req(output bit got);
      int w = 0;
      while (bus.slave_req !== 1'b1 && w < 100) begin
         tick();
         w++;
      end
      got = (bus.slave_req === 1'b1);
   endtask

   // Serves one burst as the arbiter would; returns what was observed.
   task automatic grant_burst(input int dly, input int len, output bit got,
                              output logic [24:0] addr, output logic drop);
      got  = 1'b0;
      addr = 'x;
      drop = 'x;
      wait_req(got);
      if (!got) return;
      addr = bus.slave_raddr;
      tick(dly);
      bus.arbitrate_valid = 1'b1;
      tick();
      drop = bus.slave_req;
      tick(len - 1);
      bus.arbitrate_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      bit seen = 1'b0;
      rst = 1'b1;
      tick(3);
      n_chk++; if (bus.slave_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.slave_req); else n_pass++;
      n_chk++; if (bus.slave_raddr !== 25'd0) $display("FAIL rst_addr: got %h want 0", bus.slave_raddr); else n_pass++;
      n_chk++; if (bus.slave_frame_finished !== 1'b0) $display("FAIL rst_fin: got %b want 0", bus.slave_frame_finished); else n_pass++;
      n_chk++; if (bus.frame_abort_error !== 1'b0) $display("FAIL rst_abort: got %b want 0", bus.frame_abort_error); else n_pass++;
      n_chk++; if (bus.slave_rburst_len !== 10'd0) $display("FAIL rst_blen: got %0d want 0", bus.slave_rburst_len); else n_pass++;
      rst = 1'b0;
      tick();
      n_chk++; if (bus.slave_rburst_len !== 10'd256) $display("FAIL blen: got %0d want 256", bus.slave_rburst_len); else n_pass++;
      for (int i = 0; i < 20; i++) begin
         bus.fifo_len = 10'($urandom_range(0, 1023));
         tick();
         if (bus.slave_req !== 1'b0) seen = 1'b1;
      end
      bus.fifo_len = '0;
      n_chk++; if (seen) $display("FAIL idle_req: got req want none"); else n_pass++;
   endtask

   task automatic test_full_frame();
      bit got;
      logic [24:0] a;
      logic drop;
      bit seen = 1'b0;
      load_bank(2);
      start_frame();
      for (int b = 0; b < NBURST; b++) begin
         grant_burst(5, 256, got, a, drop);
         n_chk++; if (!got || a !== exp_addr(2, b)) $display("FAIL frame_addr%0d: got %h want %h", b, a, exp_addr(2, b)); else n_pass++;
         n_chk++; if (drop !== 1'b0) $display("FAIL req_drop%0d: got %b want 0", b, drop); else n_pass++;
         n_chk++; if (bus.slave_frame_finished !== (b == NBURST - 1)) $display("FAIL fin%0d: got %b want %b", b, bus.slave_frame_finished, b == NBURST - 1); else n_pass++;
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.slave_req !== 1'b0) seen = 1'b1;
      end
      n_chk++; if (seen) $display("FAIL extra_req: got req want none"); else n_pass++;
   endtask

   task automatic test_backpressure();
      bit got;
      logic [24:0] a;
      logic drop;
      bit seen = 1'b0;
      bus.fifo_len = 10'd769;
      start_frame();
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.slave_req !== 1'b0) seen = 1'b1;
      end
      n_chk++; if (seen) $display("FAIL bp_769: got req want none"); else n_pass++;
      bus.fifo_len = 10'd768;
      tick();
      n_chk++; if (bus.slave_req !== 1'b1) $display("FAIL bp_768: got %b want 1", bus.slave_req); else n_pass++;
      grant_burst(0, 8, got, a, drop);
      n_chk++; if (!got || a !== exp_addr(2, 0)) $display("FAIL bp_addr0: got %h want %h", a, exp_addr(2, 0)); else n_pass++;
      bus.fifo_len = '0;
      bus.fifo_full_flag = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.slave_req !== 1'b0) seen = 1'b1;
      end
      n_chk++; if (seen) $display("FAIL bp_full: got req want none"); else n_pass++;
      bus.fifo_full_flag = 1'b0;
      for (int b = 1; b < NBURST; b++) begin
         grant_burst(int'($urandom_range(0, 6)), int'($urandom_range(1, 30)), got, a, drop);
         n_chk++; if (!got || a !== exp_addr(2, b)) $display("FAIL bp_addr%0d: got %h want %h", b, a, exp_addr(2, b)); else n_pass++;
      end
      n_chk++; if (bus.slave_frame_finished !== 1'b1) $display("FAIL bp_fin: got %b want 1", bus.slave_frame_finished); else n_pass++;
   endtask

   task automatic test_req_restart();
      bit got;
      logic [24:0] a;
      logic drop;
      start_frame();
      wait_req(got);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      n_chk++; if (!got || bus.frame_abort_error !== 1'b0) $display("FAIL req0_abort: got %b want 0", bus.frame_abort_error); else n_pass++;
      grant_burst(2, 10, got, a, drop);
      wait_req(got);
      n_chk++; if (!got || bus.slave_raddr !== exp_addr(2, 1)) $display("FAIL rq_addr1: got %h want %h", bus.slave_raddr, exp_addr(2, 1)); else n_pass++;
      load_bank(3);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      n_chk++; if (bus.frame_abort_error !== 1'b1) $display("FAIL rq_abort: got %b want 1", bus.frame_abort_error); else n_pass++;
      n_chk++; if (bus.slave_req !== 1'b1 || bus.slave_raddr !== exp_addr(3, 0)) $display("FAIL rq_restart: got req %b addr %h want 1 %h", bus.slave_req, bus.slave_raddr, exp_addr(3, 0)); else n_pass++;
      tick();
      n_chk++; if (bus.frame_abort_error !== 1'b0) $display("FAIL rq_abort_pulse: got %b want 0", bus.frame_abort_error); else n_pass++;
      for (int b = 0; b < NBURST; b++) begin
         grant_burst(int'($urandom_range(0, 6)), int'($urandom_range(1, 30)), got, a, drop);
         n_chk++; if (!got || a !== exp_addr(3, b)) $display("FAIL rq_addr%0d: got %h want %h", b, a, exp_addr(3, b)); else n_pass++;
      end
      n_chk++; if (bus.slave_frame_finished !== 1'b1) $display("FAIL rq_fin: got %b want 1", bus.slave_frame_finished); else n_pass++;
   endtask

   task automatic test_restart();
      bit got;
      logic [24:0] a;
      logic drop;
      start_frame();
      grant_burst(1, 20, got, a, drop);
      n_chk++; if (!got || a !== exp_addr(3, 0)) $display("FAIL mr_addr0: got %h want %h", a, exp_addr(3, 0)); else n_pass++;
      wait_req(got);
      n_chk++; if (!got || bus.slave_raddr !== exp_addr(3, 1)) $display("FAIL mr_addr1: got %h want %h", bus.slave_raddr, exp_addr(3, 1)); else n_pass++;
      bus.arbitrate_valid = 1'b1;
      tick(10);
      load_bank(1);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      n_chk++; if (bus.frame_abort_error !== 1'b1) $display("FAIL mr_abort: got %b want 1", bus.frame_abort_error); else n_pass++;
      tick();
      n_chk++; if (bus.frame_abort_error !== 1'b0 || bus.slave_req !== 1'b0) $display("FAIL mr_pulse: got abort %b req %b want 0 0", bus.frame_abort_error, bus.slave_req); else n_pass++;
      tick(20);
      bus.arbitrate_valid = 1'b0;
      tick();
      wait_req(got);
      n_chk++; if (!got || bus.slave_raddr !== exp_addr(1, 0)) $display("FAIL mr_newframe: got %h want %h", bus.slave_raddr, exp_addr(1, 0)); else n_pass++;
      // frame_start on the very cycle the grant falls
      bus.arbitrate_valid = 1'b1;
      tick(20);
      bus.arbitrate_valid = 1'b0;
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      n_chk++; if (bus.frame_abort_error !== 1'b1) $display("FAIL co_abort: got %b want 1", bus.frame_abort_error); else n_pass++;
      for (int b = 0; b < NBURST; b++) begin
         grant_burst(int'($urandom_range(0, 6)), int'($urandom_range(1, 30)), got, a, drop);
         n_chk++; if (!got || a !== exp_addr(1, b)) $display("FAIL co_addr%0d: got %h want %h", b, a, exp_addr(1, b)); else n_pass++;
      end
      n_chk++; if (bus.slave_frame_finished !== 1'b1) $display("FAIL co_fin: got %b want 1", bus.slave_frame_finished); else n_pass++;
   endtask

   task automatic test_bank_change();
      bit got;
      logic [24:0] a;
      logic drop;
      start_frame();
      grant_burst(0, 5, got, a, drop);
      n_chk++; if (!got || a !== exp_addr(1, 0)) $display("FAIL bc_addr0: got %h want %h", a, exp_addr(1, 0)); else n_pass++;
      wait_req(got);
      bus.arbitrate_valid = 1'b1;
      tick(30);
      load_bank(0);
      tick(20);
      bus.arbitrate_valid = 1'b0;
      tick();
      for (int b = 2; b < NBURST; b++) begin
         grant_burst(int'($urandom_range(0, 6)), int'($urandom_range(1, 30)), got, a, drop);
         n_chk++; if (!got || a !== exp_addr(1, b)) $display("FAIL bc_addr%0d: got %h want %h", b, a, exp_addr(1, b)); else n_pass++;
      end
      n_chk++; if (bus.slave_frame_finished !== 1'b1) $display("FAIL bc_fin: got %b want 1", bus.slave_frame_finished); else n_pass++;
      start_frame();
      grant_burst(3, 12, got, a, drop);
      n_chk++; if (!got || a !== exp_addr(0, 0)) $display("FAIL bc_next: got %h want %h", a, exp_addr(0, 0)); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit got;
      bit bad = 1'b0;
      wait_req(got);
      n_chk++; if (!got || bus.slave_raddr !== exp_addr(0, 1)) $display("FAIL rm_addr1: got %h want %h", bus.slave_raddr, exp_addr(0, 1)); else n_pass++;
      bus.arbitrate_valid = 1'b1;
      tick(10);
      rst = 1'b1;
      tick();
      n_chk++; if (bus.slave_req !== 1'b0 || bus.slave_raddr !== 25'd0) $display("FAIL rm_state: got req %b addr %h want 0 0", bus.slave_req, bus.slave_raddr); else n_pass++;
      rst = 1'b0;
      tick(3);
      bus.arbitrate_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.slave_req !== 1'b0 || bus.slave_raddr !== 25'd0) bad = 1'b1;
      end
      n_chk++; if (bad) $display("FAIL rm_idle: got req/addr activity want none"); else n_pass++;
   endtask

   task automatic test_random_frames();
      bit got;
      logic [24:0] a;
      logic drop;
      int bank;
      for (int f = 0; f < 3; f++) begin
         bank = int'($urandom_range(0, 3));
         load_bank(bank);
         bus.fifo_len = 10'($urandom_range(0, 768));
         start_frame();
         for (int b = 0; b < NBURST; b++) begin
            grant_burst(int'($urandom_range(0, 7)), int'($urandom_range(1, 40)), got, a, drop);
            n_chk++; if (!got || a !== exp_addr(bank, b)) $display("FAIL rnd%0d_addr%0d: got %h want %h", f, b, a, exp_addr(bank, b)); else n_pass++;
            bus.fifo_len = 10'($urandom_range(0, 768));
         end
         n_chk++; if (bus.slave_frame_finished !== 1'b1) $display("FAIL rnd%0d_fin: got %b want 1", f, bus.slave_frame_finished); else n_pass++;
      end
   endtask

   initial begin
      bus.frame_start     = 1'b0;
      bus.fifo_len        = '0;
      bus.fifo_full_flag  = 1'b0;
      bus.arbitrate_valid = 1'b0;
      bus.slave_rd_load   = 1'b0;
      bus.slave_rdbank    = '0;
      test_reset();
      test_full_frame();
      test_backpressure();
      test_req_restart();
      test_restart();
      test_bank_change();
      test_reset_mid();
      test_random_frames();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
